// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - transfer request/response bus between a client and spi_master
interface spi_master_if;
    logic       start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;

    // master: the client issuing transfer requests
    modport master (
        output start,
        output tx_data,
        input  busy,
        input  done,
        input  rx_data
    );

    // slave: the spi_master serving the requests
    modport slave (
        input  start,
        input  tx_data,
        output busy,
        output done,
        output rx_data
    );
endinterface

// File: rtl/spi_master.sv
// rtl/spi_master.sv - single-byte SPI mode 0 master with programmable CS setup/hold and SCK divider
module spi_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4
) (
    input  logic       clk,
    input  logic       rst,
    spi_master_if.slave bus,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       cs
);
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD
    } state_t;

    // Counters load N-1 and advance on reaching zero, so each phase lasts exactly N cycles
    // and an 8-bit counter covers the full 1..255 range without wrapping.
    localparam logic [7:0] DIV_LOAD   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_LOAD = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'(CS_HOLD - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [2:0] bit_cnt;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic       busy_r;
    logic       done_r;
    logic [7:0] rx_data_r;

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.rx_data = rx_data_r;

    // Transfer sequencer: every pin and status output is a register updated on state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            rx_data_r <= '0;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            cs        <= 1'b1;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    // The byte is captured here; later tx_data changes cannot reach the shifter.
                    if (bus.start) begin
                        tx_shift <= bus.tx_data;
                        mosi     <= bus.tx_data[7];
                        cs       <= 1'b0;
                        busy_r   <= 1'b1;
                        bit_cnt  <= '0;
                        cnt      <= SETUP_LOAD;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == 8'd0) begin
                        cnt   <= DIV_LOAD;
                        state <= LOW;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                LOW: begin
                    // miso is taken on the same edge that raises sck.
                    if (cnt == 8'd0) begin
                        sck      <= 1'b1;
                        rx_shift <= {rx_shift[6:0], miso};
                        cnt      <= DIV_LOAD;
                        state    <= HIGH;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                HIGH: begin
                    if (cnt == 8'd0) begin
                        sck     <= 1'b0;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            // mosi keeps the last bit through HOLD and IDLE.
                            cnt   <= HOLD_LOAD;
                            state <= HOLD;
                        end else begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            mosi     <= tx_shift[6];
                            cnt      <= DIV_LOAD;
                            state    <= LOW;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 8'd0) begin
                        cs        <= 1'b1;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        rx_data_r <= rx_shift;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master at two timing configurations
module tb_spi_master;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #20 clk = ~clk;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        int         cs_len;
    } exp_t;

    exp_t       exp_q [2][$];
    int         checks   = 0;
    int         failures = 0;

    logic       start_r  [2];
    logic [7:0] tx_r     [2];
    int         mode     [2];
    logic [7:0] slv_byte [2];

    logic       done_w [2];
    logic       busy_w [2];
    logic       cs_w   [2];
    logic       sck_w  [2];
    logic       mosi_w [2];
    logic [7:0] rx_w   [2];

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Peripheral behaviour: 0 = miso looped to mosi, 1 = miso tied high, 2 = shifts out slv_byte.
    function automatic logic [7:0] model_rx(int md, logic [7:0] tx, logic [7:0] sb);
        if (md == 0) return tx;
        if (md == 1) return 8'hFF;
        return sb;
    endfunction

    function automatic int model_cs_len(int i);
        int d, s, h;
        d = (i == 0) ? 4 : 1;
        s = d;
        h = d;
        return s + 2 * 8 * d + h;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int D = (gi == 0) ? 4 : 1;

        spi_master_if bus ();
        logic       miso;
        logic       sck;
        logic       mosi;
        logic       cs;
        int         edges  = 0;
        int         cs_cnt = 0;
        int         hi_cnt = 0;
        logic [7:0] bits   = 8'h00;
        logic       prev_cs  = 1'b1;
        logic       prev_sck = 1'b0;
        exp_t       e;

        assign bus.start   = start_r[gi];
        assign bus.tx_data = tx_r[gi];
        assign done_w[gi]  = bus.done;
        assign busy_w[gi]  = bus.busy;
        assign rx_w[gi]    = bus.rx_data;
        assign cs_w[gi]    = cs;
        assign sck_w[gi]   = sck;
        assign mosi_w[gi]  = mosi;

        spi_master #(
            .CLK_DIV (D),
            .CS_SETUP(D),
            .CS_HOLD (D)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus),
            .miso(miso),
            .sck (sck),
            .mosi(mosi),
            .cs  (cs)
        );

        always_comb begin
            miso = 1'b0;
            if (mode[gi] == 0)      miso = mosi;
            else if (mode[gi] == 1) miso = 1'b1;
            else if (edges < 8)     miso = slv_byte[gi][7 - edges];
        end

        always @(negedge clk) begin
            if (rst) begin
                edges    = 0;
                cs_cnt   = 0;
                hi_cnt   = 0;
                bits     = 8'h00;
                prev_cs  = 1'b1;
                prev_sck = 1'b0;
            end else begin
                if (prev_cs && !cs) begin
                    edges  = 0;
                    cs_cnt = 0;
                    bits   = 8'h00;
                end
                if (!cs) cs_cnt++;
                if (sck && !prev_sck) begin
                    bits   = {bits[6:0], mosi};
                    edges++;
                    hi_cnt = 0;
                end
                if (sck) hi_cnt++;
                if (!sck && prev_sck) check($sformatf("i%0d_sck_high_len", gi), hi_cnt, D);
                if (bus.done) begin
                    if (exp_q[gi].size() == 0) begin
                        check($sformatf("i%0d_unexpected_done", gi), 1, 0);
                    end else begin
                        e = exp_q[gi].pop_front();
                        check($sformatf("i%0d_rx_data", gi), bus.rx_data, e.rx);
                        check($sformatf("i%0d_mosi_bits", gi), bits, e.tx);
                        check($sformatf("i%0d_sck_rises", gi), edges, 8);
                        check($sformatf("i%0d_cs_low_len", gi), cs_cnt, e.cs_len);
                        check($sformatf("i%0d_busy_at_done", gi), bus.busy, 0);
                        check($sformatf("i%0d_cs_at_done", gi), cs, 1);
                    end
                end
                prev_cs  = cs;
                prev_sck = sck;
            end
        end
    end

    task automatic start_xfer(int i, logic [7:0] tx, int md, logic [7:0] sb, bit want_done);
        exp_t e;
        @(negedge clk);
        mode[i]     = md;
        slv_byte[i] = sb;
        tx_r[i]     = tx;
        start_r[i]  = 1'b1;
        if (want_done) begin
            e.tx     = tx;
            e.rx     = model_rx(md, tx, sb);
            e.cs_len = model_cs_len(i);
            exp_q[i].push_back(e);
        end
        @(negedge clk);
        start_r[i] = 1'b0;
    endtask

    task automatic wait_done(int i);
        int n;
        n = 0;
        while (!done_w[i] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!done_w[i]) check($sformatf("i%0d_done_timeout", i), 0, 1);
    endtask

    task automatic wait_rises(int i, int target);
        int   n, rises;
        logic prev;
        n = 0;
        rises = 0;
        prev = sck_w[i];
        while (rises < target && n < 3000) begin
            @(negedge clk);
            if (sck_w[i] && !prev) rises++;
            prev = sck_w[i];
            n++;
        end
        if (rises < target) check($sformatf("i%0d_rise_timeout", i), rises, target);
    endtask

    task automatic random_xfers(int i, int count);
        logic [7:0] tx, sb;
        int         md;
        for (int k = 0; k < count; k++) begin
            tx = 8'($urandom);
            sb = 8'($urandom);
            md = int'($urandom_range(0, 2));
            start_xfer(i, tx, md, sb, 1'b1);
            wait_done(i);
        end
    endtask

    initial begin
        exp_t e;
        int   n_done;
        for (int i = 0; i < 2; i++) begin
            start_r[i]  = 1'b0;
            tx_r[i]     = 8'h00;
            mode[i]     = 0;
            slv_byte[i] = 8'h00;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("i%0d_reset_cs", i), cs_w[i], 1);
            check($sformatf("i%0d_reset_sck", i), sck_w[i], 0);
            check($sformatf("i%0d_reset_mosi", i), mosi_w[i], 0);
            check($sformatf("i%0d_reset_busy", i), busy_w[i], 0);
            check($sformatf("i%0d_reset_done", i), done_w[i], 0);
            check($sformatf("i%0d_reset_rx", i), rx_w[i], 0);
        end
        rst = 1'b0;

        start_xfer(0, 8'hA5, 0, 8'h00, 1'b1);
        wait_done(0);
        start_xfer(0, 8'h3C, 0, 8'h00, 1'b1);
        wait_done(0);
        start_xfer(0, 8'h3C, 1, 8'h00, 1'b1);
        wait_done(0);
        random_xfers(0, 6);

        // A second start mid-transfer with a new tx_data must leave the byte in flight alone.
        start_xfer(0, 8'hC6, 2, 8'h5B, 1'b1);
        wait_rises(0, 3);
        tx_r[0]    = 8'h00;
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        wait_done(0);
        check("i0_busy_during_ignored", busy_w[0], 0);

        // Start in the done cycle: cs must be low again one cycle later.
        start_xfer(0, 8'h7E, 0, 8'h00, 1'b1);
        wait_done(0);
        tx_r[0]    = 8'h81;
        mode[0]    = 0;
        start_r[0] = 1'b1;
        e.tx       = 8'h81;
        e.rx       = 8'h81;
        e.cs_len   = model_cs_len(0);
        exp_q[0].push_back(e);
        @(negedge clk);
        start_r[0] = 1'b0;
        check("i0_b2b_cs_gap", cs_w[0], 0);
        check("i0_b2b_busy", busy_w[0], 1);
        wait_done(0);

        // Reset after the 5th sck rise aborts without a done pulse.
        start_xfer(0, 8'hA5, 0, 8'h00, 1'b0);
        wait_rises(0, 5);
        rst = 1'b1;
        @(negedge clk);
        check("i0_abort_cs", cs_w[0], 1);
        check("i0_abort_sck", sck_w[0], 0);
        check("i0_abort_busy", busy_w[0], 0);
        check("i0_abort_done", done_w[0], 0);
        check("i0_abort_rx", rx_w[0], 0);
        check("i0_abort_mosi", mosi_w[0], 0);
        rst = 1'b0;
        n_done = 0;
        repeat (200) begin
            @(negedge clk);
            if (done_w[0]) n_done++;
        end
        check("i0_abort_no_done", n_done, 0);
        start_xfer(0, 8'hA5, 0, 8'h00, 1'b1);
        wait_done(0);

        // Fastest timing configuration.
        start_xfer(1, 8'hA5, 0, 8'h00, 1'b1);
        wait_done(1);
        random_xfers(1, 5);

        repeat (5) @(negedge clk);
        check("i0_queue_empty", exp_q[0].size(), 0);
        check("i1_queue_empty", exp_q[1].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
